// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for the data cache.
//
// Handshake rules for this bundle:
//   CPU request : transfers on a rising edge where is_input_valid && is_ready.
//                 The cache latches addr/mem_rw/din on that edge; the CPU may
//                 change them afterwards. is_output_valid pulses for exactly
//                 one cycle per accepted request.
//   Mem request : mem_req_valid with mem_req_we/addr/wdata held stable until
//                 an edge where mem_req_valid && mem_req_ready. mem_req_valid
//                 drops the cycle after that edge.
//   Mem response: single-cycle mem_resp_valid pulse (fill data or writeback
//                 acknowledge). It may coincide with the request handshake.
interface data_cache_if;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_rw;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;

  // Cache side
  modport slave (
    input  is_input_valid, addr, mem_rw, din,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output is_ready, is_output_valid, dout, is_hit,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  // CPU + backing-memory side
  modport master (
    output is_input_valid, addr, mem_rw, din,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  is_ready, is_output_valid, dout, is_hit,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// One request in flight; at most one backing-memory transaction outstanding.
module data_cache #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_BITS   = 32 - 4 - $clog2(NUM_SETS)
) (
  input  logic       clk,
  input  logic       reset,
  data_cache_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam int IDX_W     = $clog2(NUM_SETS);
  localparam int LINE_BITS = LINE_WORDS * 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Line storage
  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] line_q [NUM_SETS];

  // Latched request (byte-offset bits are ignored, so not kept)
  logic [31:2] req_word_q;
  logic        req_rw_q;
  logic [31:0] req_din_q;
  logic        missed_q;    // first compare of this request missed
  logic        req_sent_q;  // memory request handshaken, awaiting response

  logic [IDX_W-1:0]     idx;
  logic [TAG_BITS-1:0]  req_tag;
  logic [1:0]           off;
  logic [LINE_BITS-1:0] cur_line;
  logic                 tag_hit;
  logic                 accept;
  logic                 resp_done;

  logic                 is_ready_c;
  logic                 out_valid_c;
  logic                 mem_req_valid_c;
  logic                 mem_req_we_c;
  logic [31:0]          mem_req_addr_c;
  logic [LINE_BITS-1:0] mem_req_wdata_c;

  assign idx      = req_word_q[4 +: IDX_W];
  assign req_tag  = req_word_q[31 -: TAG_BITS];
  assign off      = req_word_q[3:2];
  assign cur_line = line_q[idx];
  assign tag_hit  = valid_q[idx] && (tag_q[idx] == req_tag);
  assign accept   = bus.is_input_valid && is_ready_c;
  // A response only counts for a request that has been (or is being) accepted
  // by memory, so a stray pulse is harmless.
  assign resp_done = bus.mem_resp_valid &&
                     (req_sent_q || (mem_req_valid_c && bus.mem_req_ready));

  // Next-state and output decode
  always_comb begin
    state_next      = state;
    is_ready_c      = 1'b0;
    out_valid_c     = 1'b0;
    mem_req_valid_c = 1'b0;
    mem_req_we_c    = 1'b0;
    mem_req_addr_c  = 32'd0;
    mem_req_wdata_c = '0;
    case (state)
      IDLE: begin
        is_ready_c = 1'b1;
        if (bus.is_input_valid) state_next = COMPARE;
      end
      COMPARE: begin
        if (tag_hit) begin
          out_valid_c = 1'b1;
          state_next  = IDLE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_valid_c = !req_sent_q;
        mem_req_we_c    = 1'b1;
        mem_req_addr_c  = {tag_q[idx], idx, 4'b0000};
        mem_req_wdata_c = cur_line;
        if (resp_done) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid_c = !req_sent_q;
        mem_req_addr_c  = {req_word_q[31:4], 4'b0000};
        if (resp_done) state_next = COMPARE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, line status bits and per-request flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      missed_q   <= 1'b0;
      req_sent_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) missed_q <= 1'b0;
      else if (state == COMPARE && !tag_hit) missed_q <= 1'b1;
      if (resp_done) req_sent_q <= 1'b0;
      else if (mem_req_valid_c && bus.mem_req_ready) req_sent_q <= 1'b1;
      if (state == COMPARE && tag_hit && req_rw_q) dirty_q[idx] <= 1'b1;
      if (state == WRITEBACK && resp_done) dirty_q[idx] <= 1'b0;
      if (state == ALLOCATE && resp_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Request latch; no reset needed since it is only read after an accept
  always_ff @(posedge clk) begin
    if (accept) begin
      req_word_q <= bus.addr[31:2];
      req_rw_q   <= bus.mem_rw;
      req_din_q  <= bus.din;
    end
  end

  // Line data and tag arrays: store hits and line fills
  always_ff @(posedge clk) begin
    if (reset && state == COMPARE && tag_hit && req_rw_q)
      line_q[idx][{off, 5'b00000} +: 32] <= req_din_q;
    if (reset && state == ALLOCATE && resp_done) begin
      line_q[idx] <= bus.mem_resp_rdata;
      tag_q[idx]  <= req_tag;
    end
  end

  assign bus.is_ready        = is_ready_c;
  assign bus.is_output_valid = out_valid_c;
  assign bus.dout            = out_valid_c ? cur_line[{off, 5'b00000} +: 32] : 32'd0;
  assign bus.is_hit          = out_valid_c && !missed_q;
  assign bus.mem_req_valid   = mem_req_valid_c;
  assign bus.mem_req_we      = mem_req_we_c;
  assign bus.mem_req_addr    = mem_req_addr_c;
  assign bus.mem_req_wdata   = mem_req_wdata_c;
  assign dbg_state           = state;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios, randomized traffic, reset mid-miss.
module tb_data_cache;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_cache_if bus();
  logic [1:0] dbg_state;

  data_cache dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // memory-side drive: responder normally, main thread in manual mode
  logic         manual = 1'b0;
  logic         man_ready = 1'b0, man_resp = 1'b0;
  logic [127:0] man_rdata = '0;
  logic         rsp_ready, rsp_valid;
  logic [127:0] rsp_rdata;
  assign bus.mem_req_ready  = manual ? man_ready : rsp_ready;
  assign bus.mem_resp_valid = manual ? man_resp  : rsp_valid;
  assign bus.mem_resp_rdata = manual ? man_rdata : rsp_rdata;

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [33:0]  exp_q[$];      // {rw, hit, load data}
  logic [160:0] exp_mem_q[$];  // {we, line addr, wdata}
  int           acc_q[$];      // cycle stamp of each accept
  int           bp_cycles = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // ---------------- reference model ----------------
  logic         ref_valid [16];
  logic         ref_dirty [16];
  logic [23:0]  ref_tag   [16];
  logic [31:0]  ref_words [16][4];
  logic [127:0] ref_mem [logic [31:0]];  // model's view of backing memory
  logic [127:0] bmem    [logic [31:0]];  // responder's backing memory

  function automatic logic [127:0] default_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = la ^ (32'h1111_1111 * i) ^ 32'h5A5A_0000;
    return l;
  endfunction

  task automatic model_access(input logic [31:0] a, input logic rw, input logic [31:0] d);
    logic [3:0]   idx;
    logic [23:0]  tag;
    logic [1:0]   off;
    logic [31:0]  la, victim, data;
    logic [127:0] line;
    logic         hit;
    idx = a[7:4];
    tag = a[31:8];
    off = a[3:2];
    la  = {a[31:4], 4'b0000};
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    if (!hit) begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        victim = {ref_tag[idx], idx, 4'b0000};
        for (int i = 0; i < 4; i++) line[i*32 +: 32] = ref_words[idx][i];
        ref_mem[victim] = line;
        exp_mem_q.push_back({1'b1, victim, line});
      end
      exp_mem_q.push_back({1'b0, la, 128'd0});
      line = ref_mem.exists(la) ? ref_mem[la] : default_line(la);
      for (int i = 0; i < 4; i++) ref_words[idx][i] = line[i*32 +: 32];
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
      ref_tag[idx]   = tag;
    end
    data = 32'd0;
    if (rw) begin
      ref_words[idx][off] = d;
      ref_dirty[idx] = 1'b1;
    end else begin
      data = ref_words[idx][off];
    end
    exp_q.push_back({rw, hit, data});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!bus.is_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.is_ready) begin
      fail("ready_timeout");
      finish_run();
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic rw, input logic [31:0] d);
    wait_ready();
    bus.is_input_valid = 1'b1;
    bus.addr   = a;
    bus.mem_rw = rw;
    bus.din    = d;
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    // scramble inputs: the cache must have latched them
    bus.is_input_valid = 1'b0;
    bus.addr   = $urandom;
    bus.mem_rw = 1'($urandom_range(0, 1));
    bus.din    = $urandom;
  endtask

  task automatic cpu_req(input logic [31:0] a, input logic rw, input logic [31:0] d);
    model_access(a, rw, d);
    drive_req(a, rw, d);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp_mem_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || exp_mem_q.size() != 0) begin
      fail("drain_timeout");
      finish_run();
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- output monitor ----------------
  // A hit must complete in the cycle right after the accepting edge, so the
  // monitor sees the same cycle stamp the driver recorded at the accept.
  always @(negedge clk) begin
    logic [33:0] e;
    int acc;
    if (reset && bus.is_output_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        fail("unexpected_output");
      end else begin
        e   = exp_q.pop_front();
        acc = acc_q.pop_front();
        check("is_hit", bus.is_hit, e[32]);
        if (!e[33]) check("dout", bus.dout, e[31:0]);
        if (e[32]) check("hit_latency", cyc - acc, 0);
        else       check("miss_latency_nonzero", cyc > acc, 1);
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    logic         we0;
    logic [31:0]  a0;
    logic [127:0] wd0;
    logic [160:0] e;
    int           d;
    logic         same;
    rsp_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (!manual && reset && bus.mem_req_valid) begin
        we0 = bus.mem_req_we;
        a0  = bus.mem_req_addr;
        wd0 = bus.mem_req_wdata;
        if (exp_mem_q.size() == 0) begin
          fail("unexpected_mem_req");
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_req_we", we0, e[160]);
          check("mem_req_addr", a0, e[159:128]);
          if (e[160]) check("mem_req_wdata", wd0, e[127:0]);
        end
        d = (bp_cycles > 0) ? bp_cycles : $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          check("bp_req_valid", bus.mem_req_valid, 1);
          check("bp_req_addr", bus.mem_req_addr, a0);
          check("bp_req_we", bus.mem_req_we, we0);
          check("bp_is_ready", bus.is_ready, 0);
          check("bp_no_output", bus.is_output_valid, 0);
        end
        if (we0) bmem[a0] = wd0;
        else rsp_rdata = bmem.exists(a0) ? bmem[a0] : default_line(a0);
        rsp_ready = 1'b1;
        same = 1'($urandom_range(0, 1));
        if (same) rsp_valid = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (same) begin
          rsp_valid = 1'b0;
        end else begin
          check("req_drop_after_hs", bus.mem_req_valid, 0);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          rsp_valid = 1'b1;
          @(negedge clk);
          rsp_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    fail("global_timeout");
    finish_run();
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    logic [31:0] a;
    bus.is_input_valid = 1'b0;
    bus.addr   = 32'd0;
    bus.mem_rw = 1'b0;
    bus.din    = 32'd0;
    model_reset();
    ref_mem[32'h10] = {32'd4, 32'd3, 32'd2, 32'd1};
    bmem[32'h10]    = {32'd4, 32'd3, 32'd2, 32'd1};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_is_ready", bus.is_ready, 1);
    check("rst_out_valid", bus.is_output_valid, 0);
    check("rst_is_hit", bus.is_hit, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_mem_req_we", bus.mem_req_we, 0);
    reset = 1'b1;

    // directed: cold load, hit, store hit, dirty eviction, clean eviction
    cpu_req(32'h0000_0010, 1'b0, 32'd0);
    cpu_req(32'h0000_0018, 1'b0, 32'd0);
    cpu_req(32'h0000_0014, 1'b1, 32'hDEAD_BEEF);
    cpu_req(32'h0000_0114, 1'b0, 32'd0);
    cpu_req(32'h0000_0210, 1'b0, 32'd0);
    drain();

    // backpressure on a fill
    bp_cycles = 5;
    cpu_req(32'h0000_0314, 1'b0, 32'd0);
    drain();
    bp_cycles = 0;

    // randomized traffic over a few sets and tags to force conflicts
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      cpu_req(a, 1'($urandom_range(0, 1)), $urandom);
    end
    drain();

    // reset during a fill: leave set 1 clean first so the miss goes to ALLOCATE
    cpu_req(32'h0000_0610, 1'b0, 32'd0);
    drain();
    manual = 1'b1;
    drive_req(32'h0000_0510, 1'b0, 32'd0);
    void'(acc_q.pop_back());
    t = 0;
    @(negedge clk);
    while (!bus.mem_req_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("rmm_req_valid", bus.mem_req_valid, 1);
    check("rmm_req_we", bus.mem_req_we, 0);
    check("rmm_req_addr", bus.mem_req_addr, 32'h0000_0510);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    man_rdata = {4{32'hBAD0_BAD0}};
    man_resp  = 1'b1;
    @(negedge clk);
    man_resp  = 1'b0;
    check("rmm_is_ready", bus.is_ready, 1);
    check("rmm_no_output", bus.is_output_valid, 0);
    check("rmm_no_req", bus.mem_req_valid, 0);
    @(negedge clk);
    check("rmm_no_output_late", bus.is_output_valid, 0);
    model_reset();
    manual = 1'b0;
    cpu_req(32'h0000_0510, 1'b0, 32'd0);
    drain();

    finish_run();
  end

endmodule
